// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// IF-stage controller. It is the only block that drives PCWrite/address_in.
// It fetches from the current PC, hands each fetched word to ID one cycle
// after the memory acknowledges it, and applies ID stalls and EX redirects.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous reset, active-low
//   pc_cur         current PC (program counter address_out)
//   stall          ID cannot accept; hold instruction outputs and PC
//   redirect_valid taken branch/jump from EX this cycle
//   redirect_addr  redirect target
//   imem_req       fetch request (address on imem_addr)
//   imem_addr      fetch address, equal to pc_cur
//   imem_ack       imem_data is valid for imem_addr this cycle
//   imem_data      fetched instruction word
//   pc_write       PCWrite strobe (combinational)
//   pc_next        address_in value (combinational)
//   instr_valid    instr_out / instr_pc valid for ID (registered)
//   instr_out      instruction to ID (registered)
//   instr_pc       PC of instr_out (registered)
//   timeout_err    sticky fetch timeout flag
//
// Build option
//   IMEM_TIMEOUT_EN  when defined, a wait counter halts the sequencer after
//                    TIMEOUT_CYC consecutive un-acked fetch cycles and raises
//                    timeout_err. When undefined, fetches wait forever and
//                    timeout_err is tied low.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                PC_INC      = 2,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_next,
  output logic              instr_valid,
  output logic [15:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              timeout_err
);

`ifdef IMEM_TIMEOUT_EN
  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD} state_t;
`endif

  state_t              state_q, state_d;
  logic                instr_valid_q, instr_valid_d;
  logic [15:0]         instr_out_q, instr_out_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [15:0]         hold_buf_q, hold_buf_d;
  logic [ADDR_W-1:0]   pc_seq;
  logic                redirect_take;

`ifdef IMEM_TIMEOUT_EN
  logic [4:0]          wait_cnt_q, wait_cnt_d;
  logic                timeout_err_q, timeout_err_d;
  logic [4:0]          wait_cnt_inc;
  assign wait_cnt_inc = wait_cnt_q + 5'd1;
`endif

  assign imem_addr = pc_cur;
  assign imem_req  = (state_q == ST_FETCH);
  // Sequential successor; wraps naturally at 2^ADDR_W.
  assign pc_seq    = pc_cur + ADDR_W'(PC_INC);
  // Redirects are honoured only while actively fetching or holding.
  assign redirect_take = redirect_valid &&
                         ((state_q == ST_FETCH) || (state_q == ST_HOLD));

  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    hold_buf_d    = hold_buf_q;
    pc_write      = 1'b0;
    pc_next       = pc_cur;
`ifdef IMEM_TIMEOUT_EN
    wait_cnt_d    = '0;
    timeout_err_d = timeout_err_q;
`endif

    if (redirect_take) begin
      // Flush: drop any buffered or same-cycle word and refetch at target.
      pc_write      = 1'b1;
      pc_next       = redirect_addr;
      instr_valid_d = 1'b0;
      hold_buf_d    = '0;
      state_d       = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            if (!stall) begin
              instr_out_d   = imem_data;
              instr_pc_d    = pc_cur;
              instr_valid_d = 1'b1;
              pc_write      = 1'b1;
              pc_next       = pc_seq;
            end else begin
              // ID is busy: park the word, keep the PC on it.
              hold_buf_d = imem_data;
              state_d    = ST_HOLD;
            end
          end else begin
            if (!stall) begin
              instr_valid_d = 1'b0;
            end
`ifdef IMEM_TIMEOUT_EN
            wait_cnt_d = wait_cnt_inc;
            if (wait_cnt_inc == 5'(TIMEOUT_CYC)) begin
              timeout_err_d = 1'b1;
              state_d       = ST_HALT;
            end
`endif
          end
        end

        ST_HOLD: begin
          if (!stall) begin
            // PC was held, so pc_cur still addresses the buffered word.
            instr_out_d   = hold_buf_q;
            instr_pc_d    = pc_cur;
            instr_valid_d = 1'b1;
            pc_write      = 1'b1;
            pc_next       = pc_seq;
            state_d       = ST_FETCH;
          end
        end

`ifdef IMEM_TIMEOUT_EN
        ST_HALT: begin
          instr_valid_d = 1'b0;
        end
`endif

        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= RESET_VEC;
      hold_buf_q    <= '0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      hold_buf_q    <= hold_buf_d;
    end
  end

`ifdef IMEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Drives fetch_sequencer with directed scenarios and random stall/ack/redirect
// traffic. The bench owns the PC register (updated from the reference model's
// expected pc_write/pc_next) and an instruction memory. The reference model
// tracks "booting", "halted" and "a fetched word waiting for ID" rather than
// the design's state encoding. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
  localparam int ADDR_W      = 16;
  localparam int TIMEOUT_CYC = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc_cur;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_data;
  logic              pc_write;
  logic [ADDR_W-1:0] pc_next;
  logic              instr_valid;
  logic [15:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .ADDR_W(ADDR_W), .RESET_VEC(16'h0000), .PC_INC(2), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .pc_write(pc_write), .pc_next(pc_next),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents
  logic [15:0] mem [256];
  function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
    return mem[a[8:1]] ^ a;
  endfunction

  // Bench-owned PC register and reference model
  logic [ADDR_W-1:0] pc_reg;
  bit          m_boot, m_halted, m_pending, m_valid, m_err;
  logic [15:0] m_pend_word, m_out;
  logic [ADDR_W-1:0] m_pc;
  int          m_wait;

  task automatic model_reset();
    m_boot = 1; m_halted = 0; m_pending = 0; m_valid = 0; m_err = 0;
    m_pend_word = '0; m_out = '0; m_pc = '0; m_wait = 0;
    pc_reg = 16'h0000;
  endtask

  // One clock of traffic: drive at negedge, check combinational outputs,
  // advance the model across the posedge, check registered outputs.
  task automatic cycle(input bit st, input bit ak, input bit rv,
                       input logic [ADDR_W-1:0] ra,
                       output bit obs_req, output bit obs_pw,
                       output logic [ADDR_W-1:0] obs_pn,
                       output logic [ADDR_W-1:0] obs_addr);
    bit fetching, exp_req, exp_pw;
    logic [ADDR_W-1:0] exp_pn;
    logic [15:0] data;
    @(negedge clk);
    data = mem_word(pc_reg);
    stall = st; imem_ack = ak; redirect_valid = rv; redirect_addr = ra;
    pc_cur = pc_reg; imem_data = data;

    fetching = !m_boot && !m_halted && !m_pending;
    exp_req  = fetching;
    exp_pw   = 0;
    exp_pn   = pc_reg;
    if (!m_boot && !m_halted && rv) begin
      exp_pw = 1; exp_pn = ra;
    end else if (!m_boot && !m_halted && m_pending && !st) begin
      exp_pw = 1; exp_pn = pc_reg + 16'd2;
    end else if (fetching && ak && !st) begin
      exp_pw = 1; exp_pn = pc_reg + 16'd2;
    end

    #1;
    obs_req = imem_req; obs_pw = pc_write; obs_pn = pc_next; obs_addr = imem_addr;
    checks++;
    if (imem_req !== exp_req) begin
      errors++; $display("FAIL imem_req: got %b expected %b", imem_req, exp_req);
    end
    checks++;
    if (imem_addr !== pc_reg) begin
      errors++; $display("FAIL imem_addr: got %h expected %h", imem_addr, pc_reg);
    end
    checks++;
    if (pc_write !== exp_pw) begin
      errors++; $display("FAIL pc_write: got %b expected %b", pc_write, exp_pw);
    end
    if (exp_pw) begin
      checks++;
      if (pc_next !== exp_pn) begin
        errors++; $display("FAIL pc_next: got %h expected %h", pc_next, exp_pn);
      end
    end

    // Reference model advance
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (rv) begin
      m_valid = 0; m_pending = 0; m_wait = 0;
    end else if (m_pending) begin
      if (!st) begin
        m_out = m_pend_word; m_pc = pc_reg; m_valid = 1; m_pending = 0;
      end
    end else if (ak) begin
      m_wait = 0;
      if (!st) begin
        m_out = data; m_pc = pc_reg; m_valid = 1;
      end else begin
        m_pending = 1; m_pend_word = data;
      end
    end else begin
      if (!st) m_valid = 0;
`ifdef IMEM_TIMEOUT_EN
      m_wait++;
      if (m_wait == TIMEOUT_CYC) begin
        m_halted = 1; m_err = 1;
      end
`endif
    end
    if (exp_pw) pc_reg = exp_pn;

    @(posedge clk); #1;
    checks++;
    if (instr_valid !== m_valid) begin
      errors++; $display("FAIL instr_valid: got %b expected %b", instr_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      if (instr_out !== m_out || instr_pc !== m_pc) begin
        errors++;
        $display("FAIL instr: got %h@%h expected %h@%h", instr_out, instr_pc, m_out, m_pc);
      end
    end
    checks++;
    if (timeout_err !== m_err) begin
      errors++; $display("FAIL timeout_err: got %b expected %b", timeout_err, m_err);
    end
    $display("txn st=%b ack=%b rv=%b ra=%h pc=%h pw=%b pn=%h | valid=%b instr=%h@%h err=%b",
             st, ak, rv, ra, obs_addr, obs_pw, obs_pn, instr_valid, instr_out, instr_pc,
             timeout_err);
  endtask

  task automatic test_reset();
    stall = 0; imem_ack = 0; redirect_valid = 0; redirect_addr = '0;
    pc_cur = '0; imem_data = '0;
    reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0 || instr_pc !== 16'h0 ||
        timeout_err !== 1'b0 || imem_req !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b out=%h pc=%h err=%b req=%b pw=%b expected 0/0000/0000/0/0/0",
               instr_valid, instr_out, instr_pc, timeout_err, imem_req, pc_write);
    end
    $display("txn reset valid=%b req=%b", instr_valid, imem_req);
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_sequential();
    bit r, w; logic [ADDR_W-1:0] n, a;
    logic [ADDR_W-1:0] exp_pn [3];
    logic [ADDR_W-1:0] exp_ipc [3];
    exp_pn  = '{16'h0002, 16'h0004, 16'h0006};
    exp_ipc = '{16'h0000, 16'h0002, 16'h0004};
    cycle(0, 1, 0, '0, r, w, n, a);   // BOOT cycle
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL boot_pc_write: got %b expected 0", w);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, '0, r, w, n, a);
      checks++;
      if (w !== 1'b1 || n !== exp_pn[i] || instr_pc !== exp_ipc[i]) begin
        errors++;
        $display("FAIL seq_%0d: got pw=%b pn=%h ipc=%h expected 1 %h %h",
                 i, w, n, instr_pc, exp_pn[i], exp_ipc[i]);
      end
    end
  endtask

  task automatic test_stall_hold();
    bit r, w; logic [ADDR_W-1:0] n, a;
    logic [15:0] held;
    pc_reg = 16'h0010;
    held = mem_word(16'h0010);
    cycle(1, 1, 0, '0, r, w, n, a);
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL hold_entry_pw: got %b expected 0", w);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 0, '0, r, w, n, a);
      checks++;
      if (r !== 1'b0 || w !== 1'b0) begin
        errors++; $display("FAIL hold_wait: got req=%b pw=%b expected 0 0", r, w);
      end
    end
    cycle(0, 0, 0, '0, r, w, n, a);
    checks++;
    if (w !== 1'b1 || n !== 16'h0012 || instr_out !== held ||
        instr_pc !== 16'h0010 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got pw=%b pn=%h out=%h ipc=%h v=%b expected 1 0012 %h 0010 1",
               w, n, instr_out, instr_pc, instr_valid, held);
    end
  endtask

  task automatic test_redirect();
    bit r, w; logic [ADDR_W-1:0] n, a;
    cycle(0, 1, 0, '0, r, w, n, a);   // make instr_valid high first
    cycle(1, 1, 1, 16'h0100, r, w, n, a);
    checks++;
    if (w !== 1'b1 || n !== 16'h0100 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect: got pw=%b pn=%h v=%b expected 1 0100 0", w, n, instr_valid);
    end
    cycle(0, 0, 0, '0, r, w, n, a);
    checks++;
    if (a !== 16'h0100 || r !== 1'b1) begin
      errors++; $display("FAIL redirect_fetch: got addr=%h req=%b expected 0100 1", a, r);
    end
  endtask

  task automatic test_wrap();
    bit r, w; logic [ADDR_W-1:0] n, a;
    pc_reg = 16'hFFFE;
    cycle(0, 1, 0, '0, r, w, n, a);
    checks++;
    if (w !== 1'b1 || n !== 16'h0000 || instr_pc !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap: got pw=%b pn=%h ipc=%h expected 1 0000 FFFE", w, n, instr_pc);
    end
  endtask

  task automatic test_random();
    bit r, w; logic [ADDR_W-1:0] n, a;
    bit st, ak, rv; logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 9) < 3);
      ak = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) == 0);
      ra = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
      cycle(st, ak, rv, ra, r, w, n, a);
    end
  endtask

  task automatic test_reset_mid_hold();
    bit r, w; logic [ADDR_W-1:0] n, a;
    test_reset();
    cycle(0, 0, 0, '0, r, w, n, a);   // BOOT
    cycle(0, 1, 0, '0, r, w, n, a);   // valid word
    cycle(1, 1, 0, '0, r, w, n, a);   // into HOLD
    cycle(1, 0, 0, '0, r, w, n, a);   // still holding
    @(posedge clk); #2;
    reset = 0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b req=%b pw=%b expected 0 0 0",
               instr_valid, imem_req, pc_write);
    end
    $display("txn async reset valid=%b req=%b", instr_valid, imem_req);
    model_reset();
    stall = 0;
    @(posedge clk); #1;
    reset = 1;
    cycle(0, 0, 0, '0, r, w, n, a);   // BOOT after reset: no request
    checks++;
    if (r !== 1'b0) begin
      errors++; $display("FAIL boot_req: got %b expected 0", r);
    end
  endtask

  task automatic test_timeout();
    bit r, w; logic [ADDR_W-1:0] n, a;
    test_reset();
    cycle(0, 0, 0, '0, r, w, n, a);   // BOOT
`ifdef IMEM_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      cycle(0, 0, 0, '0, r, w, n, a);
      checks++;
      if (timeout_err !== (i == TIMEOUT_CYC)) begin
        errors++;
        $display("FAIL timeout_%0d: got %b expected %b", i, timeout_err, (i == TIMEOUT_CYC));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 16'h0200, r, w, n, a);
      checks++;
      if (r !== 1'b0 || w !== 1'b0 || timeout_err !== 1'b1) begin
        errors++;
        $display("FAIL halt: got req=%b pw=%b err=%b expected 0 0 1", r, w, timeout_err);
      end
    end
`else
    for (int i = 0; i < TIMEOUT_CYC + 5; i++) begin
      cycle(0, 0, 0, '0, r, w, n, a);
      checks++;
      if (timeout_err !== 1'b0 || r !== 1'b1) begin
        errors++;
        $display("FAIL no_timeout_%0d: got err=%b req=%b expected 0 1", i, timeout_err, r);
      end
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_sequential();
    test_stall_hold();
    test_redirect();
    test_wrap();
    test_random();
    test_reset_mid_hold();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
